// File: rtl/writeback_arbiter.sv
// Merges NUM_CH buffered result channels onto one register-file write port.
// Each channel owns a small FIFO; one head retires per cycle (round-robin or fixed priority).
module writeback_arbiter #(
   parameter int unsigned NUM_CH         = 2,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned PRIORITY_MODE  = 0
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [NUM_CH-1:0]                              ch_valid,
   output logic [NUM_CH-1:0]                              ch_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0]                   ch_data,
   input  logic [NUM_CH*REG_ADDR_WIDTH-1:0]               ch_rd,
   input  logic                                           flush,
   input  logic                                           wb_en,
   output logic                                           wb_valid,
   output logic [DATA_WIDTH-1:0]                          wb_out,
   output logic [REG_ADDR_WIDTH-1:0]                      wb_addr,
   output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]       ch_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned EW = REG_ADDR_WIDTH + DATA_WIDTH;

   logic [EW-1:0]     mem_q   [NUM_CH][FIFO_DEPTH];
   logic [CW-1:0]     count_q [NUM_CH];
   logic [AW-1:0]     wptr_q  [NUM_CH];
   logic [AW-1:0]     rptr_q  [NUM_CH];
   logic [PW-1:0]     rr_q;
   logic              wb_valid_q;
   logic [DATA_WIDTH-1:0]     wb_out_q;
   logic [REG_ADDR_WIDTH-1:0] wb_addr_q;

   logic [NUM_CH-1:0] nonempty;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop_ch;
   logic [PW-1:0]     gnt;
   logic [PW-1:0]     rr_d;
   logic              pop;
   logic [EW-1:0]     head;

   // Ready depends only on registered occupancy and flush, never on a same-cycle pop.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         nonempty[i] = (count_q[i] != '0);
         ch_ready[i] = (count_q[i] != CW'(FIFO_DEPTH)) && !flush;
         push[i]     = ch_valid[i] && ch_ready[i] &&
                       (ch_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0);
         ch_count[i*CW +: CW] = count_q[i];
      end
   end

   always_comb begin
      int idx;
      logic found;
      idx   = 0;
      found = 1'b0;
      gnt   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = (PRIORITY_MODE != 0) ? k : (int'(rr_q) + k) % NUM_CH;
         if (!found && nonempty[idx]) begin
            found = 1'b1;
            gnt   = idx[PW-1:0];
         end
      end
   end

   always_comb begin
      pop  = wb_en && !flush && (|nonempty);
      rr_d = PW'((int'(gnt) + 1) % NUM_CH);
      head = mem_q[gnt][rptr_q[gnt]];
      for (int i = 0; i < NUM_CH; i++) begin
         pop_ch[i] = pop && (int'(gnt) == i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            count_q[i] <= '0;
            wptr_q[i]  <= '0;
            rptr_q[i]  <= '0;
         end
         rr_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_out_q   <= '0;
         wb_addr_q  <= '0;
      end else if (flush) begin
         for (int i = 0; i < NUM_CH; i++) begin
            count_q[i] <= '0;
            wptr_q[i]  <= '0;
            rptr_q[i]  <= '0;
         end
         rr_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_out_q   <= '0;
         wb_addr_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
            if (pop_ch[i]) rptr_q[i] <= rptr_q[i] + 1'b1;
            case ({push[i], pop_ch[i]})
               2'b10:   count_q[i] <= count_q[i] + 1'b1;
               2'b01:   count_q[i] <= count_q[i] - 1'b1;
               default: count_q[i] <= count_q[i];
            endcase
         end
         if (pop) begin
            if (PRIORITY_MODE == 0) rr_q <= rr_d;
            wb_valid_q <= 1'b1;
            wb_out_q   <= head[DATA_WIDTH-1:0];
            wb_addr_q  <= head[EW-1:DATA_WIDTH];
         end else begin
            wb_valid_q <= 1'b0;
            wb_out_q   <= '0;
            wb_addr_q  <= '0;
         end
      end
   end

   // Storage needs no reset: occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i]) begin
            mem_q[i][wptr_q[i]] <= {ch_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH],
                                    ch_data[i*DATA_WIDTH +: DATA_WIDTH]};
         end
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_out   = wb_out_q;
   assign wb_addr  = wb_addr_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are checked every cycle against a queue-based model, plus directed literal checks.
module tb_writeback_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  ch_valid;
   logic [63:0] ch_data;
   logic [9:0]  ch_rd;
   logic        flush;
   logic        wb_en;

   logic [1:0]  rr_ready, pm_ready;
   logic        rr_wbv, pm_wbv;
   logic [31:0] rr_wbo, pm_wbo;
   logic [4:0]  rr_wba, pm_wba;
   logic [5:0]  rr_cnt, pm_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   writeback_arbiter #(.PRIORITY_MODE(0)) u_rr (
      .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_ready(rr_ready), .ch_data(ch_data),
      .ch_rd(ch_rd), .flush(flush), .wb_en(wb_en), .wb_valid(rr_wbv), .wb_out(rr_wbo),
      .wb_addr(rr_wba), .ch_count(rr_cnt)
   );

   writeback_arbiter #(.PRIORITY_MODE(1)) u_pm (
      .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_ready(pm_ready), .ch_data(ch_data),
      .ch_rd(ch_rd), .flush(flush), .wb_en(wb_en), .wb_valid(pm_wbv), .wb_out(pm_wbo),
      .wb_addr(pm_wba), .ch_count(pm_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: per (instance, channel) queue of {rd, data}; index = inst*2 + ch.
   logic [36:0] mq [4][$];
   int          rr_ptr [2];
   logic        exp_v [2];
   logic [31:0] exp_d [2];
   logic [4:0]  exp_a [2];

   always @(posedge clk) begin
      logic [1:0]  rdy;
      logic [36:0] e;
      int          g, c;
      if (reset) begin
         for (int j = 0; j < 4; j++) mq[j].delete();
         for (int m = 0; m < 2; m++) begin
            rr_ptr[m] = 0; exp_v[m] = 1'b0; exp_d[m] = '0; exp_a[m] = '0;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 2; i++) rdy[i] = (mq[m*2+i].size() < 4) && !flush;
            exp_v[m] = 1'b0; exp_d[m] = '0; exp_a[m] = '0;
            if (wb_en && !flush) begin
               g = -1;
               for (int k = 0; k < 2; k++) begin
                  c = (m == 0) ? (rr_ptr[m] + k) % 2 : k;
                  if (g < 0 && mq[m*2+c].size() > 0) g = c;
               end
               if (g >= 0) begin
                  e = mq[m*2+g].pop_front();
                  exp_v[m] = 1'b1; exp_a[m] = e[36:32]; exp_d[m] = e[31:0];
                  if (m == 0) rr_ptr[m] = (g + 1) % 2;
               end
            end
            for (int i = 0; i < 2; i++)
               if (ch_valid[i] && rdy[i] && ch_rd[i*5 +: 5] != 5'd0)
                  mq[m*2+i].push_back({ch_rd[i*5 +: 5], ch_data[i*32 +: 32]});
            if (flush) begin
               mq[m*2].delete(); mq[m*2+1].delete(); rr_ptr[m] = 0;
            end
         end
      end
      #1;
      check("rr_wb_valid", 64'(rr_wbv), 64'(exp_v[0]));
      check("rr_wb_out",   64'(rr_wbo), 64'(exp_d[0]));
      check("rr_wb_addr",  64'(rr_wba), 64'(exp_a[0]));
      check("pm_wb_valid", 64'(pm_wbv), 64'(exp_v[1]));
      check("pm_wb_out",   64'(pm_wbo), 64'(exp_d[1]));
      check("pm_wb_addr",  64'(pm_wba), 64'(exp_a[1]));
      check("rr_count0", 64'(rr_cnt[2:0]), 64'(mq[0].size()));
      check("rr_count1", 64'(rr_cnt[5:3]), 64'(mq[1].size()));
      check("pm_count0", 64'(pm_cnt[2:0]), 64'(mq[2].size()));
      check("pm_count1", 64'(pm_cnt[5:3]), 64'(mq[3].size()));
      if (!reset) begin
         check("rr_ready", 64'(rr_ready),
               64'({mq[1].size() < 4 && !flush, mq[0].size() < 4 && !flush}));
         check("pm_ready", 64'(pm_ready),
               64'({mq[3].size() < 4 && !flush, mq[2].size() < 4 && !flush}));
      end
   end

   task automatic set_ch(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
      ch_valid[i]      = v;
      ch_rd[i*5 +: 5]  = rd;
      ch_data[i*32 +: 32] = d;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; ch_valid = '0; ch_data = '0; ch_rd = '0; flush = 1'b0; wb_en = 1'b0;
      cyc(); cyc();
      reset = 1'b0;
      #1;
      check("reset_ready", 64'(rr_ready), 64'h3);
      check("reset_count", 64'(rr_cnt), 64'h0);
      check("reset_valid", 64'(rr_wbv), 64'h0);

      // Reset mid-traffic with ch0 holding 3 entries
      cyc();
      for (int j = 0; j < 3; j++) begin
         set_ch(0, 1'b1, 5'(j + 1), 32'h30 + j); cyc();
      end
      set_ch(0, 1'b0, '0, '0);
      check("t1_count_before", 64'(rr_cnt[2:0]), 64'd3);
      reset = 1'b1; #1;
      check("t1_count_async", 64'(rr_cnt), 64'h0);
      cyc(); reset = 1'b0; #1;
      check("t1_ready", 64'(rr_ready), 64'h3);
      check("t1_valid", 64'(rr_wbv), 64'h0);

      // Same-edge pushes on both channels, RR pointer at 0
      cyc(); wb_en = 1'b1;
      set_ch(0, 1'b1, 5'd5, 32'h11); set_ch(1, 1'b1, 5'd6, 32'h22);
      cyc();
      set_ch(0, 1'b0, '0, '0); set_ch(1, 1'b0, '0, '0);
      cyc();
      check("t2_first_addr", 64'(rr_wba), 64'd5);
      check("t2_first_data", 64'(rr_wbo), 64'h11);
      cyc();
      check("t2_second_addr", 64'(rr_wba), 64'd6);
      check("t2_second_data", 64'(rr_wbo), 64'h22);
      cyc();
      check("t2_idle", 64'(rr_wbv), 64'h0);

      // Fill ch0 with wb_en low; 5th valid held off; drain in order
      wb_en = 1'b0;
      for (int j = 0; j < 4; j++) begin
         set_ch(0, 1'b1, 5'(j + 1), 32'hA0 + j); cyc();
      end
      set_ch(0, 1'b1, 5'd7, 32'h55);
      #1;
      check("t3_full_ready", 64'(rr_ready[0]), 64'h0);
      cyc(); cyc();
      check("t3_full_count", 64'(rr_cnt[2:0]), 64'd4);
      set_ch(0, 1'b0, '0, '0); wb_en = 1'b1;
      for (int j = 0; j < 4; j++) begin
         cyc();
         check("t3_drain_addr", 64'(rr_wba), 64'(j + 1));
         check("t3_drain_data", 64'(rr_wbo), 64'(32'hA0 + j));
      end
      check("t3_ready_back", 64'(rr_ready[0]), 64'h1);

      // Write to x0 is accepted but dropped
      set_ch(1, 1'b1, 5'd0, 32'hDEAD); cyc();
      set_ch(1, 1'b0, '0, '0); cyc();
      check("t4_count1", 64'(rr_cnt[5:3]), 64'h0);
      check("t4_no_write", 64'(rr_wbv), 64'h0);

      // Flush with ch0=2, ch1=3 while ch0 pushes
      wb_en = 1'b0;
      for (int j = 0; j < 3; j++) begin
         set_ch(0, j < 2, 5'(8 + j), 32'h40 + j);
         set_ch(1, 1'b1, 5'(12 + j), 32'h50 + j);
         cyc();
      end
      set_ch(1, 1'b0, '0, '0);
      check("t5_pre_count", 64'(rr_cnt), 64'({3'd3, 3'd2}));
      flush = 1'b1; set_ch(0, 1'b1, 5'd9, 32'hBAD); #1;
      check("t5_flush_ready", 64'(rr_ready), 64'h0);
      cyc();
      flush = 1'b0; set_ch(0, 1'b0, '0, '0); #1;
      check("t5_counts", 64'(rr_cnt), 64'h0);
      check("t5_valid", 64'(rr_wbv), 64'h0);
      wb_en = 1'b1;
      cyc(); cyc();
      check("t5_no_ghost", 64'(rr_wbv), 64'h0);

      // Fixed priority: both channels non-empty, ch0 refilled for 6 cycles
      wb_en = 1'b0;
      for (int j = 0; j < 4; j++) begin
         set_ch(0, 1'b1, 5'(1 + j), 32'h100 + j);
         set_ch(1, 1'b1, 5'(20 + j), 32'h200 + j);
         cyc();
      end
      set_ch(1, 1'b0, '0, '0); wb_en = 1'b1;
      for (int j = 0; j < 6; j++) begin
         set_ch(0, 1'b1, 5'(10 + j), 32'h110 + j);
         cyc();
         check("t6_pm_valid", 64'(pm_wbv), 64'h1);
         check("t6_pm_ch0", 64'(pm_wba < 5'd20), 64'h1);
      end
      set_ch(0, 1'b0, '0, '0);
      for (int j = 0; j < 14; j++) cyc();
      check("t6_pm_drained", 64'(pm_cnt), 64'h0);
      check("t6_rr_drained", 64'(rr_cnt), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
